imem_power_sequencer: RTL and testbench
=======================================

// Module: imem_power_sequencer
// PURPOSE
//   Sequences the power state of the instruction memory behind the fetch stage.
//   - Gates the memory read enable per cycle.
//   - Puts the memory to sleep after a run of idle fetch cycles.
//   - Wakes it with a fixed latency, holding the PC until the memory is ready.
//   - Flags which memory outputs are valid instructions.
//   Sits between the fetch-stage PC register/stall/branch logic and the power-optimized instruction memory.
// PARAMETERS
//   IDLE_THRESH  8  consecutive non-access cycles in ACTIVE before entering SLEEP; 0 = never sleep
//   WAKE_CYCLES  2  cycles spent in WAKE before reads resume; legal range 1..(2**CNT_W-1)
//   CNT_W        4  width of idle/wake counters; must hold max(IDLE_THRESH, WAKE_CYCLES)
// PORTS
//   clk          in   1   core clock, rising edge
//   reset_n      in   1   asynchronous, active-low reset
//   fetch_req    in   1   fetch stage wants an instruction this cycle
//   stall        in   1   pipeline stall (PC frozen)
//   branch       in   1   taken branch/redirect this cycle
//   mem_enable   out  1   instruction memory read enable
//   mem_sleep    out  1   instruction memory retention/sleep request
//   hold_pc      out  1   forces fetch-stage stall while memory is not ready
//   fetch_valid  out  1   instruction bus carries a valid fetched word
//   pwr_state    out  2   00 ACTIVE, 01 SLEEP, 10 WAKE (11 unused)
//   sleep_cycles out  32  cycles spent in SLEEP (stats, see CONFIGURATION)
//   wake_events  out  16  number of SLEEP->WAKE transitions (stats)
// BEHAVIOUR
//   Reset (reset_n=0, async): state=ACTIVE, idle_cnt=0, wake_cnt=0, fetch_valid=0, counters=0.
//     Outputs during reset: mem_enable=0, mem_sleep=0, hold_pc=0.
//   access = fetch_req & !stall & !branch (combinational).
//   ACTIVE:
//     - mem_enable=access (combinational), mem_sleep=0, hold_pc=0.
//     - access=1: idle_cnt<=0.
//     - access=0: idle_cnt<=idle_cnt+1, saturating at IDLE_THRESH.
//     - If access=0, IDLE_THRESH!=0 and idle_cnt==IDLE_THRESH-1: next state SLEEP, idle_cnt<=0.
//   SLEEP:
//     - mem_enable=0, mem_sleep=1, hold_pc=fetch_req.
//     - fetch_req=1 (stall ignored; early wake hides latency): next WAKE, wake_cnt<=WAKE_CYCLES-1, wake_events++.
//     - branch alone does not wake.
//   WAKE:
//     - mem_enable=0, mem_sleep=0, hold_pc=1.
//     - wake_cnt decrements each cycle; at wake_cnt==0 next ACTIVE with idle_cnt<=0.
//     - Not abortable: fetch_req drop or branch during WAKE still completes to ACTIVE.
//   Latency: WAKE lasts exactly WAKE_CYCLES cycles, so the first read is enabled WAKE_CYCLES+1 cycles after the SLEEP-exit request.
//   fetch_valid: registered, 1-cycle memory read latency.
//     - fetch_valid<=mem_enable (previous cycle), but forced 0 if branch is high in the cycle it would assert (flush).
//   Simultaneous branch+stall+fetch_req: access=0, counts as idle.
//   Reset mid-WAKE/SLEEP: immediate return to ACTIVE with all counters cleared.
//   Illegal state 11: next state ACTIVE.
// CONFIGURATION
//   IMEM_PWR_STATS_EN defined:
//     - sleep_cycles increments every cycle in SLEEP (wraps at 2**32).
//     - wake_events increments per SLEEP->WAKE (wraps at 2**16).
//     - Both reset to 0.
//   IMEM_PWR_STATS_EN undefined: no counter flops; sleep_cycles and wake_events tied to 0. All other behaviour identical.
// TESTING
//   1. Reset release, fetch_req=1, stall=0, branch=0 for 10 cycles
//      -> pwr_state=00, mem_enable=1 every cycle, fetch_valid=1 from cycle 2.
//   2. ACTIVE, fetch_req=0 for 8 cycles (IDLE_THRESH=8)
//      -> pwr_state=01 on cycle 9, mem_sleep=1, mem_enable=0.
//   3. In SLEEP, raise fetch_req
//      -> hold_pc=1 that cycle; WAKE 2 cycles with mem_sleep=0; ACTIVE after; mem_enable=1 3 cycles after request; wake_events=1 (stats on).
//   4. ACTIVE, branch pulse with fetch_req=1
//      -> mem_enable=0 that cycle, fetch_valid=0 next cycle, idle_cnt increments by 1.
//   5. Assert reset_n=0 asynchronously mid-WAKE
//      -> pwr_state=00, hold_pc=0, fetch_valid=0 without waiting for clk.
//   6. IDLE_THRESH=0, fetch_req=0 for 100 cycles
//      -> pwr_state stays 00, sleep_cycles=0.

Source files
------------

// File: rtl/imem_power_sequencer.sv
// Power-state sequencer for the fetch-side instruction memory (ACTIVE / SLEEP / WAKE).
// Optional statistics counters are built only when IMEM_PWR_STATS_EN is defined.
module imem_power_sequencer #(
    parameter int IDLE_THRESH = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_req,
    input  logic        stall,
    input  logic        branch,
    output logic        mem_enable,
    output logic        mem_sleep,
    output logic        hold_pc,
    output logic        fetch_valid,
    output logic [1:0]  pwr_state,
    output logic [31:0] sleep_cycles,
    output logic [15:0] wake_events
);

    localparam logic [1:0] ST_ACTIVE = 2'b00;
    localparam logic [1:0] ST_SLEEP  = 2'b01;
    localparam logic [1:0] ST_WAKE   = 2'b10;

    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(IDLE_THRESH);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_THRESH - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] wake_cnt_q, wake_cnt_d;
    logic             fetch_valid_q;
    logic             access;
    logic             wake_start;

    assign access = fetch_req & ~stall & ~branch;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wake_cnt_d = wake_cnt_q;
        wake_start = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (access) begin
                    idle_cnt_d = CNT_ZERO;
                end else if ((IDLE_THRESH != 0) && (idle_cnt_q == IDLE_LAST)) begin
                    state_d    = ST_SLEEP;
                    idle_cnt_d = CNT_ZERO;
                end else if (idle_cnt_q != IDLE_MAX) begin
                    idle_cnt_d = idle_cnt_q + CNT_ONE;
                end
            end
            ST_SLEEP: begin
                // Wake on any request, even stalled ones, so the latency overlaps the stall.
                if (fetch_req) begin
                    state_d    = ST_WAKE;
                    wake_cnt_d = WAKE_LOAD;
                    wake_start = 1'b1;
                end
            end
            ST_WAKE: begin
                if (wake_cnt_q == CNT_ZERO) begin
                    state_d    = ST_ACTIVE;
                    idle_cnt_d = CNT_ZERO;
                end else begin
                    wake_cnt_d = wake_cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d    = ST_ACTIVE;
                idle_cnt_d = CNT_ZERO;
                wake_cnt_d = CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_ACTIVE;
            idle_cnt_q    <= CNT_ZERO;
            wake_cnt_q    <= CNT_ZERO;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idle_cnt_q    <= idle_cnt_d;
            wake_cnt_q    <= wake_cnt_d;
            fetch_valid_q <= mem_enable;
        end
    end

    // mem_enable gated by reset_n so no read is issued while reset is held.
    assign mem_enable = reset_n & (state_q == ST_ACTIVE) & access;
    assign mem_sleep  = (state_q == ST_SLEEP);
    assign hold_pc    = ((state_q == ST_SLEEP) & fetch_req) | (state_q == ST_WAKE);
    assign pwr_state  = state_q;

    // fetch_valid: one-cycle read latency; no ready back-pressure exists, the word is
    // consumed in the cycle fetch_valid is high, and a branch in that cycle flushes it.
    assign fetch_valid = fetch_valid_q & ~branch;

`ifdef IMEM_PWR_STATS_EN
    logic [31:0] sleep_cycles_q;
    logic [15:0] wake_events_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sleep_cycles_q <= '0;
            wake_events_q  <= '0;
        end else begin
            if (state_q == ST_SLEEP) sleep_cycles_q <= sleep_cycles_q + 32'd1;
            if (wake_start)          wake_events_q  <= wake_events_q + 16'd1;
        end
    end

    assign sleep_cycles = sleep_cycles_q;
    assign wake_events  = wake_events_q;
`else
    assign sleep_cycles = '0;
    assign wake_events  = '0;
`endif

endmodule

// File: tb/tb_imem_power_sequencer.sv
// Scoreboard bench for imem_power_sequencer: directed rows push hand-computed expectations,
// a negedge monitor pops and compares. Stats columns are zeroed unless IMEM_PWR_STATS_EN.
module tb_imem_power_sequencer;

    localparam int W = 54;

    logic        clk;
    logic        reset_n;
    logic        fetch_req, stall, branch;
    logic        mem_enable, mem_sleep, hold_pc, fetch_valid;
    logic [1:0]  pwr_state;
    logic [31:0] sleep_cycles;
    logic [15:0] wake_events;
    logic        z_mem_enable, z_mem_sleep, z_hold_pc, z_fetch_valid;
    logic [1:0]  z_pwr_state;
    logic [31:0] z_sleep_cycles;
    logic [15:0] z_wake_events;

    logic [W-1:0] exp_q[$];
    int           id_q[$];
    int           checks = 0;
    int           errors = 0;
    int           row_id = 0;

    imem_power_sequencer #(.IDLE_THRESH(8), .WAKE_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .stall(stall), .branch(branch),
        .mem_enable(mem_enable), .mem_sleep(mem_sleep), .hold_pc(hold_pc),
        .fetch_valid(fetch_valid), .pwr_state(pwr_state),
        .sleep_cycles(sleep_cycles), .wake_events(wake_events)
    );

    imem_power_sequencer #(.IDLE_THRESH(0), .WAKE_CYCLES(2), .CNT_W(4)) dut_nosleep (
        .clk(clk), .reset_n(reset_n), .fetch_req(fetch_req), .stall(stall), .branch(branch),
        .mem_enable(z_mem_enable), .mem_sleep(z_mem_sleep), .hold_pc(z_hold_pc),
        .fetch_valid(z_fetch_valid), .pwr_state(z_pwr_state),
        .sleep_cycles(z_sleep_cycles), .wake_events(z_wake_events)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: apply one cycle of inputs and push the expected outputs for that cycle
    task automatic step(input logic fr, input logic st, input logic br,
                        input logic [1:0] e_state, input logic e_me, input logic e_ms,
                        input logic e_hp, input logic e_fv,
                        input logic [15:0] e_we, input logic [31:0] e_sc);
`ifndef IMEM_PWR_STATS_EN
        e_we = '0;
        e_sc = '0;
`endif
        @(posedge clk);
        #1;
        fetch_req = fr;
        stall     = st;
        branch    = br;
        row_id++;
        exp_q.push_back({e_state, e_me, e_ms, e_hp, e_fv, e_we, e_sc});
        id_q.push_back(row_id);
    endtask

    // scoreboard monitor
    initial begin
        logic [W-1:0] e;
        int id;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                check($sformatf("row%0d", id),
                      64'({pwr_state, mem_enable, mem_sleep, hold_pc, fetch_valid,
                           wake_events, sleep_cycles}), 64'(e));
                check($sformatf("row%0d_nosleep", id),
                      64'({z_pwr_state, z_sleep_cycles}), 64'(0));
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        fetch_req = 1'b1;
        stall     = 1'b0;
        branch    = 1'b0;
        #3;
        check("reset_outputs",
              64'({pwr_state, mem_enable, mem_sleep, hold_pc, fetch_valid}), 64'(0));
        check("reset_counters", 64'({wake_events, sleep_cycles}), 64'(0));
        fetch_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // fetch stream after reset
        step(1,0,0, 2'd0,1,0,0,0, 0,0);
        for (int i = 0; i < 9; i++) step(1,0,0, 2'd0,1,0,0,1, 0,0);
        // idle run into SLEEP
        step(0,0,0, 2'd0,0,0,0,1, 0,0);
        for (int i = 0; i < 7; i++) step(0,0,0, 2'd0,0,0,0,0, 0,0);
        step(0,0,0, 2'd1,0,1,0,0, 0,0);
        step(0,0,0, 2'd1,0,1,0,0, 0,1);
        // wake request, request dropped mid-WAKE
        step(1,0,0, 2'd1,0,1,1,0, 0,2);
        step(1,0,0, 2'd2,0,0,1,0, 1,3);
        step(0,0,0, 2'd2,0,0,1,0, 1,3);
        step(1,0,0, 2'd0,1,0,0,0, 1,3);
        step(1,0,0, 2'd0,1,0,0,1, 1,3);
        // branch flush, stall, branch+stall+fetch all count as idle
        step(1,0,1, 2'd0,0,0,0,0, 1,3);
        step(1,1,0, 2'd0,0,0,0,0, 1,3);
        step(1,1,1, 2'd0,0,0,0,0, 1,3);
        for (int i = 0; i < 5; i++) step(0,0,0, 2'd0,0,0,0,0, 1,3);
        step(0,0,0, 2'd1,0,1,0,0, 1,3);
        // branch alone keeps SLEEP; stalled fetch still wakes; branch in WAKE does not abort
        step(0,0,1, 2'd1,0,1,0,0, 1,4);
        step(1,1,0, 2'd1,0,1,1,0, 1,5);
        step(0,0,1, 2'd2,0,0,1,0, 2,6);
        step(0,0,0, 2'd2,0,0,1,0, 2,6);
        step(0,0,0, 2'd0,0,0,0,0, 2,6);
        for (int i = 0; i < 7; i++) step(0,0,0, 2'd0,0,0,0,0, 2,6);
        step(1,0,0, 2'd1,0,1,1,0, 2,6);
        step(1,0,0, 2'd2,0,0,1,0, 3,7);

        // asynchronous reset in the middle of WAKE
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_state",
              64'({pwr_state, hold_pc, fetch_valid, mem_enable, mem_sleep}), 64'(0));
        check("async_rst_counters", 64'({wake_events, sleep_cycles}), 64'(0));
        fetch_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(1,0,0, 2'd0,1,0,0,0, 0,0);
        step(1,0,0, 2'd0,1,0,0,1, 0,0);

        // long idle: main instance sleeps, zero-threshold instance never does
        for (int i = 1; i <= 100; i++)
            step(0,0,0, (i <= 8) ? 2'd0 : 2'd1, 1'b0, (i > 8), 1'b0, (i == 1),
                 16'd0, (i <= 8) ? 32'd0 : 32'(i - 9));

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
